// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Six-digit multiplexed seven-segment driver for an HH:MM:SS BCD time counter.
//   The asynchronous digit bus is synchronised (s1, s2), compared against a
//   third stage (s3), and a snapshot is taken once per frame only when s2 and
//   s3 agree, so a frame never mixes old and new digits. The snapshot is then
//   scanned onto a common-anode display, one digit per SCAN_DIV-cycle slot,
//   with the first cycle of every slot blanked to hide ghosting.
//
// Parameters
//   SCAN_DIV      clock cycles per digit slot (>= 2)
//   BLINK_FRAMES  frames per separator blink half-period (>= 1)
//
// Ports
//   clock        display clock
//   reset        synchronous, active-high
//   enable       1 = scan, 0 = dark outputs with scan position held
//   ms_hr..ls_sec  BCD digits, asynchronous to clock
//   seg_n        segment cathodes a..g (bit0 = a), active-low
//   dp_n         decimal point, active-low (HH.MM.SS separator)
//   an_n         digit anodes, active-low; an_n[5] = ms_hr .. an_n[0] = ls_sec
//   frame_start  one-cycle pulse with the first (blanked) cycle of slot 0
//
// Build option
//   LEADING_ZERO_BLANK_EN  blank the ms_hr digit when it is zero
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] ms_hr,
  input  logic [3:0] ls_hr,
  input  logic [3:0] ms_min,
  input  logic [3:0] ls_min,
  input  logic [3:0] ms_sec,
  input  logic [3:0] ls_sec,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  logic [23:0]   din, s1, s2, s3, snap;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [BW-1:0] blk_cnt;
  logic          blink;

  logic [3:0] cur_dig;
  logic [6:0] seg_nxt;
  logic [5:0] an_nxt;
  logic       dp_nxt;
  logic       frame_pt;

  assign din = {ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec};

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h3F; // illegal BCD: dash (g only)
    endcase
  endfunction

  // Slot index 0 is the leftmost digit (ms_hr), i.e. the top nibble.
  always_comb begin
    cur_dig = snap[3:0];
    case (idx)
      3'd0:    cur_dig = snap[23:20];
      3'd1:    cur_dig = snap[19:16];
      3'd2:    cur_dig = snap[15:12];
      3'd3:    cur_dig = snap[11:8];
      3'd4:    cur_dig = snap[7:4];
      default: cur_dig = snap[3:0];
    endcase
  end

  always_comb begin
    seg_nxt = dec7(cur_dig);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3'd0 && cur_dig == 4'd0) seg_nxt = 7'h7F;
`endif
  end

  // First cycle of each slot keeps every anode off while segments change.
  assign an_nxt   = (presc == '0) ? 6'h3F : ~(6'b100000 >> idx);
  assign dp_nxt   = ~(blink && (idx == 3'd1 || idx == 3'd3));
  assign frame_pt = (idx == 3'd0) && (presc == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      snap        <= '0;
      presc       <= '0;
      idx         <= '0;
      blk_cnt     <= '0;
      blink       <= 1'b0;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      an_n        <= 6'h3F;
      frame_start <= 1'b0;
    end else begin
      // Synchroniser runs regardless of enable so it is settled on resume.
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      if (enable) begin
        seg_n       <= seg_nxt;
        dp_n        <= dp_nxt;
        an_n        <= an_nxt;
        frame_start <= frame_pt;
        // Tear filter: only latch a bus that was stable for two cycles.
        if (frame_pt && s2 == s3) snap <= s2;
        if (presc == PRE_LAST) begin
          presc <= '0;
          if (idx == 3'd5) begin
            idx <= '0;
            if (blk_cnt == BLK_LAST) begin
              blk_cnt <= '0;
              blink   <= ~blink;
            end else begin
              blk_cnt <= blk_cnt + 1'b1;
            end
          end else begin
            idx <= idx + 3'd1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        seg_n       <= 7'h7F;
        dp_n        <= 1'b1;
        an_n        <= 6'h3F;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV = 4, BLINK_FRAMES = 2
// (24-cycle frames). Outputs are sampled on the falling edge; a frame is
// captured starting at the frame_start sample, so sample k belongs to slot
// k/4 at prescaler k%4.
module tb_seg7_scan_driver;
  localparam int SD = 4;
  localparam int BF = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] digits = 24'h123456;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  an_n;
  logic        frame_start;

  int total = 0;
  int bad = 0;

  logic [6:0] cs [64];
  logic [5:0] ca [64];
  logic       cd [64];
  logic       cf [64];
  int         waited, extra;

  always #5 clock = ~clock;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ms_hr(digits[23:20]), .ls_hr(digits[19:16]), .ms_min(digits[15:12]),
    .ls_min(digits[11:8]), .ms_sec(digits[7:4]), .ls_sec(digits[3:0]),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_start(frame_start)
  );

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [5:0] exp_an(input int k);
    if (k % 4 == 0) return 6'h3F;
    return ~(6'b100000 >> (k / 4));
  endfunction

  function automatic logic [3:0] nib(input logic [23:0] d, input int slot);
    return d[(5 - slot) * 4 +: 4];
  endfunction

  // Capture n samples starting at the next frame_start; optionally change the
  // digit bus at sample chg_k and drop enable at sample dis_k for dis_len cycles.
  task automatic grab(input int n, input int chg_k, input logic [23:0] chg_val,
                      input int dis_k, input int dis_len);
    waited = 0;
    @(negedge clock);
    while (frame_start !== 1'b1 && waited < 200) begin
      waited++;
      @(negedge clock);
    end
    extra = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clock);
      cs[i] = seg_n; ca[i] = an_n; cd[i] = dp_n; cf[i] = frame_start;
      if (i > 0 && frame_start === 1'b1) extra++;
      if (i == chg_k) digits = chg_val;
      if (i == dis_k) enable = 1'b0;
      if (i == dis_k + dis_len) enable = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; digits = 24'h123456;
    repeat (3) @(negedge clock);
    total++; if (seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=7f", seg_n); end
    total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp_n); end
    total++; if (an_n !== 6'h3F) begin bad++; $display("FAIL reset_an got=%h want=3f", an_n); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
  endtask

  task automatic test_scan();
    reset = 1'b0;
    grab(24, -1, 24'h0, -1, 0);
    total++; if (waited != 0) begin bad++; $display("FAIL scan_first_fs waited=%0d want=0", waited); end
    for (int k = 0; k < 24; k++) begin
      total++; if (ca[k] !== exp_an(k)) begin bad++; $display("FAIL scan1_an k=%0d got=%h want=%h", k, ca[k], exp_an(k)); end
      total++; if (cd[k] !== 1'b1) begin bad++; $display("FAIL scan1_dp k=%0d got=%b want=1", k, cd[k]); end
      if (k % 4 != 0) begin
        total++; if (cs[k] !== 7'h40) begin bad++; $display("FAIL scan1_seg k=%0d got=%h want=40", k, cs[k]); end
      end
    end
    grab(24, -1, 24'h0, -1, 0);
    for (int k = 0; k < 24; k++) begin
      total++; if (ca[k] !== exp_an(k)) begin bad++; $display("FAIL scan2_an k=%0d got=%h want=%h", k, ca[k], exp_an(k)); end
      if (k % 4 != 0) begin
        total++; if (cs[k] !== exp_seg(nib(24'h123456, k / 4))) begin
          bad++; $display("FAIL scan2_seg k=%0d got=%h want=%h", k, cs[k], exp_seg(nib(24'h123456, k / 4)));
        end
      end
    end
  endtask

  // Frames 3..8: separator lit on slots 1 and 3 in frames 3,4,7,8.
  task automatic test_blink();
    for (int f = 3; f <= 8; f++) begin
      logic on;
      on = (f == 3 || f == 4 || f == 7 || f == 8);
      grab(24, -1, 24'h0, -1, 0);
      total++; if (waited != 0) begin bad++; $display("FAIL blink_period f=%0d waited=%0d want=0", f, waited); end
      total++; if (extra != 0) begin bad++; $display("FAIL blink_extra_fs f=%0d got=%0d want=0", f, extra); end
      for (int k = 0; k < 24; k++) begin
        logic want;
        want = ~(on && (k / 4 == 1 || k / 4 == 3));
        total++; if (cd[k] !== want) begin bad++; $display("FAIL blink_dp f=%0d k=%0d got=%b want=%b", f, k, cd[k], want); end
      end
    end
  endtask

  task automatic test_tear();
    int          ck  [7] = '{0, -1, 10, -1, 21, -1, -1};
    logic [23:0] cv  [7] = '{24'h235959, 24'h0, 24'h0, 24'h0, 24'h235959, 24'h0, 24'h0};
    logic [23:0] ex  [7] = '{24'h0, 24'h235959, 24'h235959, 24'h0, 24'h0, 24'h0, 24'h235959};
    for (int f = 0; f < 7; f++) begin
      grab(24, ck[f], cv[f], -1, 0);
      if (f == 0) continue;
      for (int k = 0; k < 24; k++) begin
        total++; if (ca[k] !== exp_an(k)) begin bad++; $display("FAIL tear_an f=%0d k=%0d got=%h want=%h", f, k, ca[k], exp_an(k)); end
        if (k % 4 != 0) begin
          total++; if (cs[k] !== exp_seg(nib(ex[f], k / 4))) begin
            bad++; $display("FAIL tear_seg f=%0d k=%0d got=%h want=%h", f, k, cs[k], exp_seg(nib(ex[f], k / 4)));
          end
        end
      end
    end
  endtask

  task automatic test_illegal();
    grab(24, 0, 24'h123C56, -1, 0);
    grab(24, -1, 24'h0, -1, 0);
    for (int k = 1; k < 24; k++) begin
      if (k % 4 != 0) begin
        logic [6:0] want;
        want = (k / 4 == 3) ? 7'h3F : exp_seg(nib(24'h123C56, k / 4));
        total++; if (cs[k] !== want) begin bad++; $display("FAIL illegal_seg k=%0d got=%h want=%h", k, cs[k], want); end
      end
    end
  endtask

  task automatic test_enable();
    grab(34, -1, 24'h0, 9, 10);
    total++; if (extra != 0) begin bad++; $display("FAIL en_extra_fs got=%0d want=0", extra); end
    for (int i = 0; i < 34; i++) begin
      if (i >= 10 && i < 20) begin
        total++; if ({cs[i], cd[i], ca[i], cf[i]} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
          bad++; $display("FAIL en_dark i=%0d got=%h/%b/%h/%b want=7f/1/3f/0", i, cs[i], cd[i], ca[i], cf[i]);
        end
      end else begin
        int k;
        k = (i < 10) ? i : i - 10;
        total++; if (ca[i] !== exp_an(k)) begin bad++; $display("FAIL en_an i=%0d got=%h want=%h", i, ca[i], exp_an(k)); end
        if (k % 4 != 0) begin
          total++; if (cs[i] !== exp_seg(nib(24'h123C56, k / 4))) begin
            bad++; $display("FAIL en_seg i=%0d got=%h want=%h", i, cs[i], exp_seg(nib(24'h123C56, k / 4)));
          end
        end
      end
    end
    grab(24, -1, 24'h0, -1, 0);
    total++; if (waited != 0) begin bad++; $display("FAIL en_period waited=%0d want=0", waited); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] want0;
`ifdef LEADING_ZERO_BLANK_EN
    want0 = 7'h7F;
`else
    want0 = 7'h40;
`endif
    grab(24, 0, 24'h012345, -1, 0);
    grab(24, 0, 24'h123456, -1, 0);
    for (int k = 1; k < 4; k++) begin
      total++; if (ca[k] !== 6'h1F) begin bad++; $display("FAIL lz_an k=%0d got=%h want=1f", k, ca[k]); end
      total++; if (cs[k] !== want0) begin bad++; $display("FAIL lz_seg0 k=%0d got=%h want=%h", k, cs[k], want0); end
    end
    total++; if (cs[5] !== 7'h79) begin bad++; $display("FAIL lz_seg1 got=%h want=79", cs[5]); end
    grab(24, -1, 24'h0, -1, 0);
    total++; if (cs[2] !== 7'h79) begin bad++; $display("FAIL lz_one got=%h want=79", cs[2]); end
  endtask

  task automatic test_mid_reset();
    grab(8, -1, 24'h0, -1, 0);
    reset = 1'b1;
    @(negedge clock);
    total++; if ({seg_n, dp_n, an_n, frame_start} !== {7'h7F, 1'b1, 6'h3F, 1'b0}) begin
      bad++; $display("FAIL midrst_out got=%h/%b/%h/%b want=7f/1/3f/0", seg_n, dp_n, an_n, frame_start);
    end
    reset = 1'b0;
    grab(24, -1, 24'h0, -1, 0);
    total++; if (waited != 0) begin bad++; $display("FAIL midrst_fs waited=%0d want=0", waited); end
    for (int k = 1; k < 24; k++) begin
      if (k % 4 != 0) begin
        total++; if (cs[k] !== 7'h40) begin bad++; $display("FAIL midrst_seg k=%0d got=%h want=40", k, cs[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_tear();
    test_illegal();
    test_enable();
    test_leading_zero();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
